// File: rtl/wb_write_arbiter_if.sv
// Register-file write-port arbiter bus: MEM/WB request, mul/div result
// handshake, ID-stage hazard query and the registered register-file write.
interface wb_write_arbiter_if #(
    parameter int unsigned DW = 32
);
    // MEM/WB pipeline write request
    logic          pipe_regwrite;
    logic [4:0]    pipe_rd;
    logic [DW-1:0] pipe_data;
    logic          pipe_stall;

    // mul/div result handshake
    logic          md_valid;
    logic [4:0]    md_rd;
    logic [DW-1:0] md_data;
    logic          md_ready;

    // ID-stage pending-write query
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic          rs_pending;
    logic          rt_pending;

    // register-file write port
    logic          regwrite;
    logic [4:0]    rd;
    logic [DW-1:0] writedata;

    // Pipeline / mul/div / ID side
    modport master (
        output pipe_regwrite, pipe_rd, pipe_data,
        input  pipe_stall,
        output md_valid, md_rd, md_data,
        input  md_ready,
        output rs, rt,
        input  rs_pending, rt_pending,
        input  regwrite, rd, writedata
    );

    // Arbiter side
    modport slave (
        input  pipe_regwrite, pipe_rd, pipe_data,
        output pipe_stall,
        input  md_valid, md_rd, md_data,
        output md_ready,
        input  rs, rt,
        output rs_pending, rt_pending,
        output regwrite, rd, writedata
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// Arbitrates the single register-file write port between the in-order MEM/WB
// result and queued mul/div results. Mul/div results drain on cycles the
// pipeline leaves free; a wait counter forces a drain (stalling the pipeline)
// when the queue has been starved for MAX_WAIT cycles.
module wb_write_arbiter #(
    parameter int unsigned DW       = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_WAIT = 8
) (
    input logic               clk,
    input logic               rst,
    wb_write_arbiter_if.slave bus
);
    localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

    localparam logic [PtrW-1:0]  PtrOne   = PtrW'(1);
    localparam logic [CntW-1:0]  CntOne   = CntW'(1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(DEPTH);
    localparam logic [WaitW-1:0] WaitOne  = WaitW'(1);
    localparam logic [WaitW-1:0] WaitMax  = WaitW'(MAX_WAIT);

    // Result queue storage
    logic [4:0]       fifo_rd_q   [DEPTH];
    logic [DW-1:0]    fifo_data_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    // Starvation counter
    logic [WaitW-1:0] wait_q, wait_d;

    // Registered write port
    logic             regwrite_q, regwrite_d;
    logic [4:0]       rd_q, rd_d;
    logic [DW-1:0]    wdata_q, wdata_d;

    // Decoded control
    logic             fifo_empty;
    logic             fifo_ready;
    logic             stall;
    logic             pipe_wr;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] entry_valid;
    logic             rs_fifo_hit;
    logic             rt_fifo_hit;

    assign fifo_empty = (count_q == '0);
    // Ready depends only on occupancy: a full queue never accepts, even on a pop.
    assign fifo_ready = (count_q < CntFull);
    assign stall      = (wait_q == WaitMax) && !fifo_empty;
    // A write to $0 is treated as no write at all.
    assign pipe_wr    = bus.pipe_regwrite && (bus.pipe_rd != 5'd0);
    // Results for $0 are accepted but never queued.
    assign push       = bus.md_valid && fifo_ready && (bus.md_rd != 5'd0);
    // A forced drain wins over the pipeline; otherwise drain only on free slots.
    assign pop        = stall || (!pipe_wr && !fifo_empty);

    // An entry is live when its distance from the head is below the occupancy.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry_valid
        logic [PtrW-1:0] offset;
        assign offset         = PtrW'(g) - rd_ptr_q;
        assign entry_valid[g] = (CntW'(offset) < count_q);
    end

    // Output-register next state: forced/idle drain, else pipeline, else idle.
    always_comb begin
        regwrite_d = 1'b0;
        rd_d       = rd_q;
        wdata_d    = wdata_q;
        if (pop) begin
            regwrite_d = 1'b1;
            rd_d       = fifo_rd_q[rd_ptr_q];
            wdata_d    = fifo_data_q[rd_ptr_q];
        end else if (pipe_wr) begin
            regwrite_d = 1'b1;
            rd_d       = bus.pipe_rd;
            wdata_d    = bus.pipe_data;
        end
    end

    // Queue pointer and occupancy next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    // Starvation counter: cleared by any drain or an empty queue, saturating.
    always_comb begin
        wait_d = wait_q;
        if (pop || fifo_empty) begin
            wait_d = '0;
        end else if (wait_q != WaitMax) begin
            wait_d = wait_q + WaitOne;
        end
    end

    // Scan live queue entries for the ID-stage source registers.
    always_comb begin
        rs_fifo_hit = 1'b0;
        rt_fifo_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (fifo_rd_q[i] == bus.rs)) begin
                rs_fifo_hit = 1'b1;
            end
            if (entry_valid[i] && (fifo_rd_q[i] == bus.rt)) begin
                rt_fifo_hit = 1'b1;
            end
        end
    end

    // Control state registers; reset drops queued results and the output write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wait_q     <= '0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            wdata_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wait_q     <= wait_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            wdata_q    <= wdata_d;
        end
    end

    // Queue storage write on push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_rd_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
        end else if (push) begin
            fifo_rd_q[wr_ptr_q]   <= bus.md_rd;
            fifo_data_q[wr_ptr_q] <= bus.md_data;
        end
    end

    assign bus.md_ready   = fifo_ready;
    assign bus.pipe_stall = stall;
    assign bus.regwrite   = regwrite_q;
    assign bus.rd         = rd_q;
    assign bus.writedata  = wdata_q;

    // $0 is never pending; otherwise pending if queued or in the output register.
    assign bus.rs_pending = (bus.rs != 5'd0) &&
                            (rs_fifo_hit || (regwrite_q && (rd_q == bus.rs)));
    assign bus.rt_pending = (bus.rt != 5'd0) &&
                            (rt_fifo_hit || (regwrite_q && (rd_q == bus.rt)));

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter (DW=32, DEPTH=4, MAX_WAIT=8).
module tb_wb_write_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    wb_write_arbiter_if #(.DW(32)) bus ();

    wb_write_arbiter #(
        .DW       (32),
        .DEPTH    (4),
        .MAX_WAIT (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.pipe_regwrite = 1'b0;
        bus.pipe_rd       = 5'd0;
        bus.pipe_data     = 32'h0;
        bus.md_valid      = 1'b0;
        bus.md_rd         = 5'd0;
        bus.md_data       = 32'h0;
        bus.rs            = 5'd0;
        bus.rt            = 5'd0;

        // Reset state
        #2;
        check("rst_regwrite", 32'(bus.regwrite), 32'd0);
        check("rst_rd", 32'(bus.rd), 32'd0);
        check("rst_writedata", bus.writedata, 32'h0);
        check("rst_md_ready", 32'(bus.md_ready), 32'd1);
        check("rst_pipe_stall", 32'(bus.pipe_stall), 32'd0);
        check("rst_rs_pending", 32'(bus.rs_pending), 32'd0);
        check("rst_rt_pending", 32'(bus.rt_pending), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Pipeline write only
        bus.pipe_regwrite = 1'b1;
        bus.pipe_rd       = 5'd5;
        bus.pipe_data     = 32'h1234;
        bus.rs            = 5'd5;
        tick();
        check("pipe_regwrite", 32'(bus.regwrite), 32'd1);
        check("pipe_rd", 32'(bus.rd), 32'd5);
        check("pipe_data", bus.writedata, 32'h1234);
        check("pipe_rs_pending", 32'(bus.rs_pending), 32'd1);
        bus.pipe_rd = 5'd0;
        tick();
        check("pipe_rd0_regwrite", 32'(bus.regwrite), 32'd0);
        check("pipe_rd0_rd_hold", 32'(bus.rd), 32'd5);
        check("pipe_rd0_rs_pending", 32'(bus.rs_pending), 32'd0);
        bus.pipe_regwrite = 1'b0;
        bus.rs            = 5'd0;

        // Idle drain with rt pending tracking
        bus.md_valid = 1'b1;
        bus.md_rd    = 5'd7;
        bus.md_data  = 32'hAA;
        bus.rt       = 5'd7;
        settle();
        check("drain_md_ready", 32'(bus.md_ready), 32'd1);
        check("drain_rt_pre", 32'(bus.rt_pending), 32'd0);
        tick();
        bus.md_valid = 1'b0;
        settle();
        check("drain_queued_regwrite", 32'(bus.regwrite), 32'd0);
        check("drain_rt_queued", 32'(bus.rt_pending), 32'd1);
        tick();
        check("drain_regwrite", 32'(bus.regwrite), 32'd1);
        check("drain_rd", 32'(bus.rd), 32'd7);
        check("drain_data", bus.writedata, 32'hAA);
        check("drain_rt_out", 32'(bus.rt_pending), 32'd1);
        tick();
        check("drain_done_regwrite", 32'(bus.regwrite), 32'd0);
        check("drain_done_rt", 32'(bus.rt_pending), 32'd0);
        bus.rt = 5'd0;

        // Fill the queue while the pipeline writes every cycle
        bus.pipe_regwrite = 1'b1;
        bus.md_valid      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.pipe_rd   = 5'(10 + i);
            bus.pipe_data = 32'h100 + 32'(i);
            bus.md_rd     = 5'(1 + i);
            bus.md_data   = 32'hB1 + 32'(i);
            settle();
            check("fill_md_ready", 32'(bus.md_ready), 32'd1);
            tick();
            check("fill_rd", 32'(bus.rd), 32'(10 + i));
            check("fill_data", bus.writedata, 32'h100 + 32'(i));
        end
        // Fifth result offered while full must be held
        bus.pipe_regwrite = 1'b0;
        bus.md_rd         = 5'd5;
        bus.md_data       = 32'hB5;
        settle();
        check("full_md_ready", 32'(bus.md_ready), 32'd0);
        check("full_pipe_stall", 32'(bus.pipe_stall), 32'd0);
        tick();
        check("full_out1_rd", 32'(bus.rd), 32'd1);
        check("full_out1_data", bus.writedata, 32'hB1);
        check("full_after_pop_ready", 32'(bus.md_ready), 32'd1);
        tick();
        bus.md_valid = 1'b0;
        check("full_out2_rd", 32'(bus.rd), 32'd2);
        tick();
        check("full_out3_rd", 32'(bus.rd), 32'd3);
        tick();
        check("full_out4_rd", 32'(bus.rd), 32'd4);
        tick();
        check("full_out5_rd", 32'(bus.rd), 32'd5);
        check("full_out5_data", bus.writedata, 32'hB5);
        check("full_out5_regwrite", 32'(bus.regwrite), 32'd1);
        tick();
        check("full_empty_regwrite", 32'(bus.regwrite), 32'd0);

        // Starvation: one queued entry, pipeline writes continuously
        bus.pipe_regwrite = 1'b1;
        bus.pipe_rd       = 5'd20;
        bus.md_valid      = 1'b1;
        bus.md_rd         = 5'd9;
        bus.md_data       = 32'hC9;
        bus.rs            = 5'd9;
        for (int k = 0; k < 9; k++) begin
            bus.pipe_data = 32'h2000 + 32'(k);
            tick();
            if (k == 0) bus.md_valid = 1'b0;
            check("starve_stall", 32'(bus.pipe_stall), (k == 8) ? 32'd1 : 32'd0);
            check("starve_data", bus.writedata, 32'h2000 + 32'(k));
        end
        check("starve_rs_pending", 32'(bus.rs_pending), 32'd1);
        bus.pipe_data = 32'h2009;
        settle();
        check("starve_stall_hold", 32'(bus.pipe_stall), 32'd1);
        tick();
        check("starve_pop_rd", 32'(bus.rd), 32'd9);
        check("starve_pop_data", bus.writedata, 32'hC9);
        check("starve_stall_clear", 32'(bus.pipe_stall), 32'd0);
        tick();
        check("starve_held_regwrite", 32'(bus.regwrite), 32'd1);
        check("starve_held_rd", 32'(bus.rd), 32'd20);
        check("starve_held_data", bus.writedata, 32'h2009);
        check("starve_rs_clear", 32'(bus.rs_pending), 32'd0);
        bus.pipe_regwrite = 1'b0;
        bus.rs            = 5'd0;
        tick();

        // Register $0 on both sources
        bus.md_valid      = 1'b1;
        bus.md_rd         = 5'd0;
        bus.md_data       = 32'hDD;
        bus.pipe_regwrite = 1'b1;
        bus.pipe_rd       = 5'd0;
        bus.pipe_data     = 32'hEE;
        settle();
        check("zero_md_ready", 32'(bus.md_ready), 32'd1);
        tick();
        bus.md_valid      = 1'b0;
        bus.pipe_regwrite = 1'b0;
        check("zero_regwrite1", 32'(bus.regwrite), 32'd0);
        check("zero_rs_pending", 32'(bus.rs_pending), 32'd0);
        tick();
        check("zero_regwrite2", 32'(bus.regwrite), 32'd0);
        check("zero_stall", 32'(bus.pipe_stall), 32'd0);

        // Async reset with three queued entries and an active output write
        bus.pipe_regwrite = 1'b1;
        bus.pipe_rd       = 5'd3;
        bus.pipe_data     = 32'h33;
        bus.md_valid      = 1'b1;
        for (int j = 0; j < 3; j++) begin
            bus.md_rd   = 5'(11 + j);
            bus.md_data = 32'hE0 + 32'(j);
            tick();
        end
        bus.md_valid = 1'b0;
        bus.rs       = 5'd11;
        bus.rt       = 5'd13;
        settle();
        check("prerst_regwrite", 32'(bus.regwrite), 32'd1);
        check("prerst_rs_pending", 32'(bus.rs_pending), 32'd1);
        check("prerst_rt_pending", 32'(bus.rt_pending), 32'd1);
        rst = 1'b1;
        settle();
        check("arst_regwrite", 32'(bus.regwrite), 32'd0);
        check("arst_rd", 32'(bus.rd), 32'd0);
        check("arst_writedata", bus.writedata, 32'h0);
        check("arst_md_ready", 32'(bus.md_ready), 32'd1);
        check("arst_rs_pending", 32'(bus.rs_pending), 32'd0);
        check("arst_rt_pending", 32'(bus.rt_pending), 32'd0);
        bus.pipe_regwrite = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("postrst_regwrite1", 32'(bus.regwrite), 32'd0);
        tick();
        check("postrst_regwrite2", 32'(bus.regwrite), 32'd0);
        check("postrst_stall", 32'(bus.pipe_stall), 32'd0);
        check("postrst_rs_pending", 32'(bus.rs_pending), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
